button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 19 +
 rtl/sync_2ff.sv | 25 ++
 rtl/button_conditioner.sv | 135 +++++++++++++
 tb/tb_button_conditioner.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b11,
    RELEASE_WAIT = 2'b10
  } state_e;

  localparam int DEBOUNCE_CYCLES_DEFAULT   = 4;
  localparam int LONG_PRESS_CYCLES_DEFAULT = 16;

  // Button is considered held while pressed or while a release is still being qualified.
  function automatic logic is_down(input state_e st);
    return (st == PRESSED) || (st == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Capture the asynchronous input and re-time it through a second stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/button_conditioner.sv
// Debounces a raw push-button into a clean level plus press/release pulses.
// Optional held-press detection is enabled with the BUTTON_LONG_PRESS_EN macro.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic B,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic s1,
  output logic s0
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             b_r;
  logic             press_r;
  logic             release_r;
  logic             btn_sync_s;
  logic             press_entry_s;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (btn_raw),
    .q     (btn_sync_s)
  );

  assign press_entry_s = (state_r == PRESS_WAIT) && btn_sync_s && (cnt_r == CNT_LAST);

  // Debounce FSM; every terminal count value forces a transition so cnt_r never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      b_r       <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (btn_sync_s) begin
            state_r <= PRESS_WAIT;
            cnt_r   <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        PRESS_WAIT: begin
          if (!btn_sync_s) begin
            state_r <= IDLE;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= PRESSED;
            b_r     <= 1'b1;
            press_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!btn_sync_s) begin
            state_r <= RELEASE_WAIT;
            cnt_r   <= '0;
          end else begin
            state_r <= PRESSED;
          end
        end
        RELEASE_WAIT: begin
          if (btn_sync_s) begin
            state_r <= PRESSED;
          end else if (cnt_r == CNT_LAST) begin
            state_r   <= IDLE;
            b_r       <= 1'b0;
            release_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          b_r     <= 1'b0;
        end
      endcase
    end
  end

  assign B             = b_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign s1            = state_r[1];
  assign s0            = state_r[0];

`ifdef BUTTON_LONG_PRESS_EN
  localparam logic [15:0] LONG_TARGET = 16'(LONG_PRESS_CYCLES);

  logic [15:0] long_cnt_r;
  logic        long_r;

  // Hold-time counter: restarts only on a fresh press, so bounces keep accumulating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      long_cnt_r <= 16'd0;
      long_r     <= 1'b0;
    end else begin
      long_r <= 1'b0;
      if (press_entry_s) begin
        long_cnt_r <= 16'd0;
      end else if (is_down(state_r) && (long_cnt_r != 16'hFFFF)) begin
        long_cnt_r <= long_cnt_r + 16'd1;
        long_r     <= ((long_cnt_r + 16'd1) == LONG_TARGET);
      end else begin
        long_cnt_r <= long_cnt_r;
      end
    end
  end

  assign long_press = long_r;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: segment table, corner sequences, random runs.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int L = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_raw = 1'b0;
  logic B, press_pulse, release_pulse, long_press, s1, s0;

  always #3 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .B             (B),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .s1            (s1),
    .s0            (s0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: raw level seen by the FSM two edges late; a level change is
  // accepted after D+1 consecutive differing samples; hold time counted in cycles.
  bit mdl_dly [2];
  bit mdl_lvl;
  int mdl_run;
  int mdl_held;
  bit m_press, m_rel, m_long;

  int cyc = 0;
  int seg_press, seg_rel, seg_long;
  int last_press_cyc, last_long_cyc;

  typedef struct {
    bit         raw;
    int         cycles;
    bit         exp_b;
    int         exp_press;
    int         exp_rel;
    logic [1:0] exp_s;
  } seg_t;

  seg_t segs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mdl_dly[0] = 1'b0;
    mdl_dly[1] = 1'b0;
    mdl_lvl    = 1'b0;
    mdl_run    = 0;
    mdl_held   = 0;
    m_press    = 1'b0;
    m_rel      = 1'b0;
    m_long     = 1'b0;
  endtask

  task automatic model_step(input bit raw);
    bit seen;
    seen       = mdl_dly[1];
    mdl_dly[1] = mdl_dly[0];
    mdl_dly[0] = raw;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    if (mdl_lvl && mdl_held < 65535) begin
      mdl_held++;
      m_long = (mdl_held == L);
    end
    if (seen != mdl_lvl) begin
      mdl_run++;
      if (mdl_run == D + 1) begin
        mdl_lvl = seen;
        mdl_run = 0;
        if (seen) begin
          m_press  = 1'b1;
          mdl_held = 0;
        end else begin
          m_rel = 1'b1;
        end
      end
    end else begin
      mdl_run = 0;
    end
  endtask

  task automatic tick(input bit raw);
    logic [5:0] exp_v;
    bit         exp_long;
    btn_raw = raw;
    @(posedge clk);
    model_step(raw);
    @(negedge clk);
    cyc++;
`ifdef BUTTON_LONG_PRESS_EN
    exp_long = m_long;
`else
    exp_long = 1'b0;
`endif
    exp_v = {mdl_lvl, m_press, m_rel, exp_long, mdl_lvl, mdl_lvl ^ (mdl_run != 0)};
    check("outputs{B,press,release,long,s1,s0}",
          {26'd0, B, press_pulse, release_pulse, long_press, s1, s0}, {26'd0, exp_v});
    check("press_and_release_together", {31'd0, press_pulse & release_pulse}, 32'd0);
    if (press_pulse === 1'b1) begin
      seg_press++;
      last_press_cyc = cyc;
    end
    if (release_pulse === 1'b1) seg_rel++;
    if (long_press === 1'b1) begin
      seg_long++;
      last_long_cyc = cyc;
    end
  endtask

  task automatic clear_counts();
    seg_press = 0;
    seg_rel   = 0;
    seg_long  = 0;
  endtask

  // Assert reset between clock edges, verify the immediate effect, hold it one edge, release.
  task automatic pulse_reset(input string name);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check({name, "_async"}, {26'd0, B, press_pulse, release_pulse, long_press, s1, s0}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({name, "_held"}, {26'd0, B, press_pulse, release_pulse, long_press, s1, s0}, 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] lat_s [8];
    int start_cyc;
    int exp_long_cnt;

    segs[0]  = '{1'b1, 20, 1'b1, 1, 0, 2'b11};  // clean press
    segs[1]  = '{1'b0, 20, 1'b0, 0, 1, 2'b00};  // clean release
    segs[2]  = '{1'b1,  2, 1'b0, 0, 0, 2'b00};  // short glitch
    segs[3]  = '{1'b0, 10, 1'b0, 0, 0, 2'b00};
    segs[4]  = '{1'b1,  4, 1'b0, 0, 0, 2'b01};  // one sample short of qualifying
    segs[5]  = '{1'b0, 10, 1'b0, 0, 0, 2'b00};
    segs[6]  = '{1'b1,  5, 1'b0, 0, 0, 2'b01};  // shortest qualifying press
    segs[7]  = '{1'b0, 12, 1'b0, 1, 1, 2'b00};
    segs[8]  = '{1'b1, 10, 1'b1, 1, 0, 2'b11};  // press, then blip during release
    segs[9]  = '{1'b0,  2, 1'b1, 0, 0, 2'b11};
    segs[10] = '{1'b1,  1, 1'b1, 0, 0, 2'b10};
    segs[11] = '{1'b0, 10, 1'b0, 0, 1, 2'b00};

    lat_s = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11};

    model_reset();
    last_press_cyc = 0;
    last_long_cyc  = 0;
    #7;
    check("reset_outputs", {26'd0, B, press_pulse, release_pulse, long_press, s1, s0}, 32'd0);
    reset = 1'b1;
    clear_counts();
    for (int i = 0; i < 4; i++) tick(1'b0);
    check("post_reset_pulses", seg_press + seg_rel, 32'd0);

    for (int r = 0; r < 12; r++) begin
      clear_counts();
      for (int c = 0; c < segs[r].cycles; c++) tick(segs[r].raw);
      check($sformatf("seg%0d_B", r), {31'd0, B}, {31'd0, segs[r].exp_b});
      check($sformatf("seg%0d_press_count", r), seg_press, segs[r].exp_press);
      check($sformatf("seg%0d_release_count", r), seg_rel, segs[r].exp_rel);
      check($sformatf("seg%0d_state", r), {30'd0, s1, s0}, {30'd0, segs[r].exp_s});
    end

    // Press latency and long-press hold from a settled idle line.
    for (int i = 0; i < 3; i++) tick(1'b0);
    clear_counts();
    start_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1);
      check($sformatf("latency_state_%0d", i + 1), {30'd0, s1, s0}, {30'd0, lat_s[i]});
    end
    check("press_edge", last_press_cyc - start_cyc, 32'd7);
    for (int i = 0; i < 22; i++) tick(1'b1);
`ifdef BUTTON_LONG_PRESS_EN
    exp_long_cnt = 1;
    check("long_press_offset", last_long_cyc - last_press_cyc, L);
`else
    exp_long_cnt = 0;
`endif
    check("long_press_count", seg_long, exp_long_cnt);
    check("hold_press_count", seg_press, 32'd1);
    for (int i = 0; i < 10; i++) tick(1'b0);

    // Reset while a press is still being qualified.
    clear_counts();
    for (int i = 0; i < 4; i++) tick(1'b1);
    pulse_reset("reset_mid_debounce");
    for (int i = 0; i < 8; i++) tick(1'b0);
    check("mid_debounce_pulses", seg_press + seg_rel, 32'd0);

    // Reset during an accepted press with the button still held.
    for (int i = 0; i < 10; i++) tick(1'b1);
    clear_counts();
    pulse_reset("reset_mid_press");
    start_cyc = cyc;
    for (int i = 0; i < 7; i++) tick(1'b1);
    check("repress_count", seg_press, 32'd1);
    check("repress_edge", last_press_cyc - start_cyc, 32'd7);
    check("repress_no_release", seg_rel, 32'd0);
    for (int i = 0; i < 10; i++) tick(1'b0);

    // Random bouncy runs against the model.
    for (int n = 0; n < 120; n++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) tick(lvl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
